// File: rtl/apb_led_sequencer.sv
// APB LED pattern sequencer: a table of LED patterns with per-step dwell is replayed once or in a loop.
// Optional PWM brightness stage is enabled by defining APB_LED_SEQ_PWM_EN.
module apb_led_sequencer #(
  parameter int NUM_STEPS  = 8,
  parameter int PRESCALE_W = 24
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [15:0] PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [7:0]  LED,
  output logic        SEQ_IRQ
);
  localparam int IW = $clog2(NUM_STEPS);
  localparam logic [9:0] PAT_BASE = 10'h010;
  localparam logic [9:0] PAT_END  = 10'(16 + NUM_STEPS);

  // APB handshake: a write is accepted on the access cycle (PSEL & PENABLE & PWRITE);
  // PREADY is always high so every transfer completes with no wait states.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [7:0]            dwell_cnt, dwell_nxt;
  logic [PRESCALE_W-1:0] pre_cnt, pre_nxt;
  logic [7:0]            led_r, led_nxt;
  logic                  done_set;

  logic                  ctrl_en, ctrl_loop, ctrl_irq_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [IW-1:0]         last;
  logic [7:0]            manual;
  logic                  done;
  logic [15:0]           pattern [NUM_STEPS];
  logic [15:0]           cur_pat;

  logic [9:0]    word;
  logic [9:0]    pat_off;
  logic [IW-1:0] pat_i;
  logic          pat_hit, wr_en, wr_ctrl, wr_status;
  logic          unused_bits;

  assign word      = PADDR[11:2];
  assign pat_off   = word - PAT_BASE;
  assign pat_i     = pat_off[IW-1:0];
  assign pat_hit   = (word >= PAT_BASE) && (word < PAT_END);
  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign wr_ctrl   = wr_en && (word == 10'h000);
  assign wr_status = wr_en && (word == 10'h001);
  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign SEQ_IRQ   = done & ctrl_irq_en;
  assign cur_pat   = pattern[idx];
  assign unused_bits = ^{PADDR[15:12], PADDR[1:0], PWDATA[31:16], pat_off};

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_en     <= 1'b0;
      ctrl_loop   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      prescale    <= '0;
      last        <= '0;
      manual      <= '0;
      done        <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= PWDATA[0];
        ctrl_loop   <= PWDATA[1];
        ctrl_irq_en <= PWDATA[4];
      end
      if (wr_en && word == 10'h002) prescale <= PWDATA[PRESCALE_W-1:0];
      if (wr_en && word == 10'h003) last     <= PWDATA[IW-1:0];
      if (wr_en && word == 10'h004) manual   <= PWDATA[7:0];
      if (wr_en && pat_hit)         pattern[pat_i] <= PWDATA[15:0];
      // A completion in the same cycle as a clear keeps DONE set.
      if (done_set)                       done <= 1'b1;
      else if (wr_status && PWDATA[8])    done <= 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= S_IDLE;
      idx       <= '0;
      dwell_cnt <= '0;
      pre_cnt   <= '0;
      led_r     <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      dwell_cnt <= dwell_nxt;
      pre_cnt   <= pre_nxt;
      led_r     <= led_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell_cnt;
    pre_nxt   = pre_cnt;
    led_nxt   = led_r;
    done_set  = 1'b0;
    case (state)
      S_IDLE: led_nxt = manual;
      S_LOAD: begin
        led_nxt   = cur_pat[7:0];
        dwell_nxt = (cur_pat[15:8] == 8'd0) ? 8'd1 : cur_pat[15:8];
        pre_nxt   = prescale;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (pre_cnt != '0) begin
          pre_nxt = pre_cnt - 1'b1;
        end else begin
          pre_nxt   = prescale;
          dwell_nxt = dwell_cnt - 8'd1;
          if (dwell_cnt <= 8'd1) begin
            if (idx >= last) begin
              if (ctrl_loop) begin
                idx_nxt   = '0;
                state_nxt = S_LOAD;
              end else begin
                done_set  = 1'b1;
                state_nxt = S_IDLE;
              end
            end else begin
              idx_nxt   = idx + {{(IW-1){1'b0}}, 1'b1};
              state_nxt = S_LOAD;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // STOP (or clearing EN) beats START; both override the running sequence.
    if (wr_ctrl) begin
      if (PWDATA[3] || !PWDATA[0]) begin
        state_nxt = S_IDLE;
        done_set  = 1'b0;
      end else if (PWDATA[2]) begin
        state_nxt = S_LOAD;
        idx_nxt   = '0;
        done_set  = 1'b0;
      end
    end
  end

`ifdef APB_LED_SEQ_PWM_EN
  logic [4:0] bright;
  logic [3:0] pwm_cnt;
  logic [7:0] led_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      bright  <= 5'd16;
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      if (wr_en && word == 10'h005) bright <= PWDATA[4:0];
      pwm_cnt <= pwm_cnt + 4'd1;
      led_q   <= led_r & {8{({1'b0, pwm_cnt} < bright)}};
    end
  end
  assign LED = led_q;
`else
  logic [4:0] bright;
  assign bright = 5'd0;
  assign LED    = led_r;
`endif

  always_comb begin
    PRDATA = '0;
    case (word)
      10'h000: PRDATA[4:0] = {ctrl_irq_en, 2'b00, ctrl_loop, ctrl_en};
      10'h001: begin
        PRDATA[0]    = (state != S_IDLE);
        PRDATA[IW:1] = idx;
        PRDATA[8]    = done;
      end
      10'h002: PRDATA[PRESCALE_W-1:0] = prescale;
      10'h003: PRDATA[IW-1:0] = last;
      10'h004: PRDATA[7:0] = manual;
      10'h005: PRDATA[4:0] = bright;
      default: if (pat_hit) PRDATA[15:0] = pattern[pat_i];
    endcase
  end
endmodule

// File: tb/tb_apb_led_sequencer.sv
// Directed bench for apb_led_sequencer: register access, one-shot, loop, restart, reset and PWM cases.
module tb_apb_led_sequencer;
  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, SEQ_IRQ;
  logic [7:0]  LED;

  int n_checks = 0;
  int n_errors = 0;

`ifdef APB_LED_SEQ_PWM_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  apb_led_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .LED(LED), .SEQ_IRQ(SEQ_IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [9:0] word, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = {4'b0, word, 2'b00}; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] word, output logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
    PADDR = {4'b0, word, 2'b00};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 data = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Step j (1-based, counted from the LOAD edge) of the 0x01/0x02/0x04 table: 4 + 7 + 4 cycles.
  function automatic logic [7:0] step_led(input int j);
    int m;
    m = (j - 1) % 15;
    if (m < 4)       return 8'h01;
    else if (m < 11) return 8'h02;
    else             return 8'h04;
  endfunction

  logic [31:0] rd;
  logic [7:0]  exp_led;
  int          j;

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    tick(3);
    PRESET = 1'b0;

    check("reset_led", {24'b0, LED}, 32'h0);
    check("reset_irq", {31'b0, SEQ_IRQ}, 32'h0);
    check("pready", {31'b0, PREADY}, 32'h1);
    check("pslverr", {31'b0, PSLVERR}, 32'h0);
    apb_read(10'h000, rd); check("reset_ctrl", rd, 32'h0);
    apb_read(10'h001, rd); check("reset_status", rd, 32'h0);
    apb_read(10'h002, rd); check("reset_prescale", rd, 32'h0);
    apb_read(10'h003, rd); check("reset_last", rd, 32'h0);
    apb_read(10'h004, rd); check("reset_manual", rd, 32'h0);
    apb_read(10'h005, rd); check("reset_bright", rd, (LAT == 1) ? 32'd16 : 32'd0);
    apb_read(10'h010, rd); check("reset_pattern0", rd, 32'h0);

    apb_write(10'h004, 32'hA5);
    check("manual_lag", {24'b0, LED}, 32'h0);
    tick(1 + LAT);
    check("manual_led", {24'b0, LED}, 32'hA5);

    apb_write(10'h002, 32'd2);
    apb_write(10'h003, 32'd2);
    apb_write(10'h010, 32'h0101);
    apb_write(10'h011, 32'h0202);
    apb_write(10'h012, 32'h0004);
    apb_write(10'h006, 32'hFFFF_FFFF);
    apb_read(10'h002, rd); check("rb_prescale", rd, 32'd2);
    apb_read(10'h003, rd); check("rb_last", rd, 32'd2);
    apb_read(10'h011, rd); check("rb_pattern1", rd, 32'h0202);
    apb_read(10'h006, rd); check("unmapped_06", rd, 32'h0);
    apb_read(10'h018, rd); check("unmapped_18", rd, 32'h0);

    // One-shot run with IRQ enabled.
    apb_write(10'h000, 32'h15);
    for (int k = 0; k < 18; k++) begin
      j = k - LAT;
      exp_led = (j >= 1 && j <= 15) ? step_led(j) : 8'hA5;
      check($sformatf("oneshot_led_k%0d", k), {24'b0, LED}, {24'b0, exp_led});
      tick(1);
    end
    apb_read(10'h001, rd); check("oneshot_status", rd, 32'h104);
    check("oneshot_irq", {31'b0, SEQ_IRQ}, 32'h1);
    apb_read(10'h000, rd); check("ctrl_readback", rd, 32'h11);
    apb_write(10'h001, 32'h100);
    apb_read(10'h001, rd); check("w1c_status", rd, 32'h004);
    check("w1c_irq", {31'b0, SEQ_IRQ}, 32'h0);

    // Loop mode: three full periods, no DONE.
    apb_write(10'h000, 32'h07);
    for (int k = 0; k < 46; k++) begin
      j = k - LAT;
      exp_led = (j >= 1) ? step_led(j) : 8'hA5;
      check($sformatf("loop_led_k%0d", k), {24'b0, LED}, {24'b0, exp_led});
      tick(1);
    end
    apb_read(10'h001, rd); check("loop_busy_nodone", rd & 32'h101, 32'h001);
    apb_write(10'h000, 32'h0F);
    tick(1 + LAT);
    check("stop_led_manual", {24'b0, LED}, 32'hA5);
    apb_read(10'h001, rd); check("stop_status", rd & 32'h101, 32'h0);

    // Restart from the middle of step 2.
    apb_write(10'h000, 32'h05);
    tick(6);
    apb_write(10'h000, 32'h05);
    check("pre_restart_led", {24'b0, LED}, 32'h02);
    tick(1);
    apb_read(10'h001, rd); check("restart_status", rd, 32'h001);
    check("restart_led", {24'b0, LED}, 32'h01);

    // Reset in the middle of a hold.
    tick(3);
    PRESET = 1'b1;
    tick(1);
    check("preset_led", {24'b0, LED}, 32'h0);
    PRESET = 1'b0;
    apb_read(10'h001, rd); check("preset_status", rd, 32'h0);
    apb_read(10'h000, rd); check("preset_ctrl", rd, 32'h0);

`ifdef APB_LED_SEQ_PWM_EN
    begin
      int on_cnt;
      apb_write(10'h004, 32'hFF);
      apb_write(10'h005, 32'd4);
      tick(4);
      on_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        if (LED == 8'hFF) on_cnt++;
        tick(1);
      end
      check("pwm_bright4_on", on_cnt, 32'd4);
      apb_write(10'h005, 32'd0);
      tick(4);
      on_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        if (LED != 8'h00) on_cnt++;
        tick(1);
      end
      check("pwm_bright0_on", on_cnt, 32'd0);
    end
`else
    apb_write(10'h005, 32'h1F);
    apb_read(10'h005, rd); check("bright_disabled", rd, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
